mem_arb_seq: RTL

MEM_ARB_SEQ -- requirements
Module: mem_arb_seq

---
 rtl/mem_arb_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arb_seq.sv
// mem_arb_seq: two-port round-robin arbiter that sequences byte, halfword and
// word accesses onto a byte-wide memory port, one byte per clock.
module mem_arb_seq #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [1:0]               size0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [31:0]              wdata0,
  output logic                     ack0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [1:0]               size1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [31:0]              wdata1,
  output logic                     ack1,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state_r;
  logic [1:0]               cnt_r;
  logic                     last_r;
  logic                     gnt_r;
  logic                     we_r;
  logic [1:0]               size_r;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [31:0]              wdata_r;
  logic                     ack0_r;
  logic                     ack1_r;
  logic                     busy_r;
  logic [31:0]              rdata_r;
  logic                     mem_we_r;
  logic [ADDRESS_WIDTH-1:0] mem_a_r;
  logic [DATA_WIDTH-1:0]    mem_wd_r;

  logic                     any_req_s;
  logic                     win_s;
  logic                     sel_we_s;
  logic [1:0]               sel_size_s;
  logic [ADDRESS_WIDTH-1:0] sel_addr_s;
  logic [31:0]              sel_wdata_s;
  logic [1:0]               cnt_last_s;
  logic [1:0]               cnt_nx_s;
  logic [ADDRESS_WIDTH-1:0] addr_nx_s;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Byte 0 of a load clears the upper bytes so short loads zero-extend.
  function automatic logic [31:0] rd_merge(input logic [31:0] old, input logic [7:0] b,
                                           input logic [1:0] i);
    logic [31:0] r;
    case (i)
      2'd0:    r = {24'h000000, b};
      2'd1:    r = {old[31:16], b, old[7:0]};
      2'd2:    r = {old[31:24], b, old[15:0]};
      default: r = {b, old[23:0]};
    endcase
    return r;
  endfunction

  // Round-robin pick: on a tie the port not served last wins.
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      win_s = ~last_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      sel_we_s    = we1;
      sel_size_s  = size1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_size_s  = size0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Last byte index of the latched access and the next byte address.
  always_comb begin
    case (size_r)
      2'b00:   cnt_last_s = 2'd0;
      2'b01:   cnt_last_s = 2'd1;
      default: cnt_last_s = 2'd3;
    endcase
    cnt_nx_s  = cnt_r + 2'd1;
    addr_nx_s = addr_r + {{(ADDRESS_WIDTH-2){1'b0}}, cnt_nx_s};
  end

  // Sequencer FSM; memory-side outputs are registered one step ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 2'd0;
      last_r   <= 1'b1;
      gnt_r    <= 1'b0;
      we_r     <= 1'b0;
      size_r   <= 2'b00;
      addr_r   <= {ADDRESS_WIDTH{1'b0}};
      wdata_r  <= 32'h00000000;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
      rdata_r  <= 32'h00000000;
      mem_we_r <= 1'b0;
      mem_a_r  <= {ADDRESS_WIDTH{1'b0}};
      mem_wd_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (any_req_s) begin
            state_r  <= ST_XFER;
            cnt_r    <= 2'd0;
            gnt_r    <= win_s;
            last_r   <= win_s;
            we_r     <= sel_we_s;
            size_r   <= sel_size_s;
            addr_r   <= sel_addr_s;
            wdata_r  <= sel_wdata_s;
            busy_r   <= 1'b1;
            mem_we_r <= sel_we_s;
            mem_a_r  <= sel_addr_s;
            mem_wd_r <= byte_of(sel_wdata_s, 2'd0);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (!we_r) begin
            rdata_r <= rd_merge(rdata_r, mem_rd, cnt_r);
          end else begin
            rdata_r <= rdata_r;
          end
          if (cnt_r == cnt_last_s) begin
            state_r  <= ST_DONE;
            ack0_r   <= ~gnt_r;
            ack1_r   <= gnt_r;
            mem_we_r <= 1'b0;
            mem_wd_r <= {DATA_WIDTH{1'b0}};
            mem_a_r  <= addr_r;
          end else begin
            cnt_r    <= cnt_nx_s;
            mem_a_r  <= addr_nx_s;
            mem_wd_r <= byte_of(wdata_r, cnt_nx_s);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          busy_r   <= 1'b0;
          mem_we_r <= 1'b0;
          mem_wd_r <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign ack0   = ack0_r;
  assign ack1   = ack1_r;
  assign busy   = busy_r;
  assign rdata  = rdata_r;
  assign mem_we = mem_we_r;
  assign mem_a  = mem_a_r;
  assign mem_wd = mem_wd_r;

endmodule
